// File: rtl/pe_dataflow_sequencer.sv
// pe_dataflow_sequencer
//   Address sequencer for a PE array with four data streams: weight (W),
//   input (I), output-in (OI) and output-out (OO). Each stream has its own
//   advance strobe. The I, OI and OO streams walk a configured number of
//   blocks per job. When all three have finished, the FSM issues a
//   one-cycle done pulse. The W stream free-runs modulo W_GROUP.
//
// Ports
//   clk, aclr            clock; asynchronous active-high reset
//   sclr_i               synchronous clear, highest priority
//   start_i              job start pulse (taken only in IDLE)
//   cfg_blocks_i         blocks per job (0 gives an immediate done)
//   en_w_i/en_i_i/en_oi_i/en_oo_i   per-stream advance strobes
//   w_addr_o, i_addr_o, oi_addr_o, oo_addr_o   PE addresses
//   i_blk_o, oi_blk_o, oo_blk_o                per-stream block index
//   busy_o, done_o, overrun_o                  status; overrun is sticky
//
// state | meaning
// IDLE  | waiting for start; only the W stream moves
// RUN   | job active; I/OI/OO strobes accepted until each stream finishes
// DONE  | single-cycle completion pulse
module pe_dataflow_sequencer #(
  parameter int W_GROUP = 4,
  parameter int O_GROUP = 4,
  parameter int I_GROUP = W_GROUP + O_GROUP - 1,
  parameter int W_AW    = 2,
  parameter int O_AW    = 2,
  parameter int I_AW    = 3,
  parameter int BLK_W   = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             sclr_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] cfg_blocks_i,
  input  logic             en_w_i,
  input  logic             en_i_i,
  input  logic             en_oi_i,
  input  logic             en_oo_i,
  output logic [W_AW-1:0]  w_addr_o,
  output logic [I_AW-1:0]  i_addr_o,
  output logic [O_AW-1:0]  oi_addr_o,
  output logic [O_AW-1:0]  oo_addr_o,
  output logic [BLK_W-1:0] i_blk_o,
  output logic [BLK_W-1:0] oi_blk_o,
  output logic [BLK_W-1:0] oo_blk_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W_AW-1:0] W_LAST    = W_AW'(W_GROUP - 1);
  localparam logic [O_AW-1:0] O_LAST    = O_AW'(O_GROUP - 1);
  localparam logic [I_AW-1:0] I_LAST_B0 = I_AW'(I_GROUP - 1);
  localparam logic [I_AW-1:0] I_LAST_BN = I_AW'(O_GROUP - 1);
  localparam logic [I_AW-1:0] I_SHIFT   = I_AW'(W_GROUP - 1);

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   cfg_q, cfg_d;
  logic [W_AW-1:0]    w_ptr_q, w_ptr_d;
  logic [I_AW-1:0]    i_ptr_q, i_ptr_d;
  logic [O_AW-1:0]    oi_ptr_q, oi_ptr_d;
  logic [O_AW-1:0]    oo_ptr_q, oo_ptr_d;
  logic [BLK_W-1:0]   i_blk_q, i_blk_d;
  logic [BLK_W-1:0]   oi_blk_q, oi_blk_d;
  logic [BLK_W-1:0]   oo_blk_q, oo_blk_d;
  logic               i_fin_q, i_fin_d;
  logic               oi_fin_q, oi_fin_d;
  logic               oo_fin_q, oo_fin_d;
  logic               overrun_q, overrun_d;

  logic               run;
  logic               acc_i, acc_oi, acc_oo;
  logic [I_AW-1:0]    i_last;
  logic [BLK_W-1:0]   blk_last;

  assign run      = (state_q == RUN);
  assign acc_i    = en_i_i  & run & ~i_fin_q;
  assign acc_oi   = en_oi_i & run & ~oi_fin_q;
  assign acc_oo   = en_oo_i & run & ~oo_fin_q;
  // Block 0 of the input stream covers the full window; later blocks only
  // fetch the O_GROUP new entries because the rest of the window is reused.
  assign i_last   = (i_blk_q == '0) ? I_LAST_B0 : I_LAST_BN;
  // cfg_q is non-zero whenever RUN is reachable, so this cannot underflow
  // while it matters.
  assign blk_last = cfg_q - BLK_W'(1);

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    w_ptr_d   = w_ptr_q;
    i_ptr_d   = i_ptr_q;
    oi_ptr_d  = oi_ptr_q;
    oo_ptr_d  = oo_ptr_q;
    i_blk_d   = i_blk_q;
    oi_blk_d  = oi_blk_q;
    oo_blk_d  = oo_blk_q;
    i_fin_d   = i_fin_q;
    oi_fin_d  = oi_fin_q;
    oo_fin_d  = oo_fin_q;
    overrun_d = overrun_q;

    if (sclr_i) begin
      state_d   = IDLE;
      cfg_d     = '0;
      w_ptr_d   = '0;
      i_ptr_d   = '0;
      oi_ptr_d  = '0;
      oo_ptr_d  = '0;
      i_blk_d   = '0;
      oi_blk_d  = '0;
      oo_blk_d  = '0;
      i_fin_d   = 1'b0;
      oi_fin_d  = 1'b0;
      oo_fin_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (en_w_i) begin
        w_ptr_d = (w_ptr_q == W_LAST) ? '0 : w_ptr_q + W_AW'(1);
      end

      if (acc_i) begin
        if (i_ptr_q == i_last) begin
          i_ptr_d = '0;
          if (i_blk_q == blk_last) begin
            i_blk_d = '0;
            i_fin_d = 1'b1;
          end else begin
            i_blk_d = i_blk_q + BLK_W'(1);
          end
        end else begin
          i_ptr_d = i_ptr_q + I_AW'(1);
        end
      end

      if (acc_oi) begin
        if (oi_ptr_q == O_LAST) begin
          oi_ptr_d = '0;
          if (oi_blk_q == blk_last) begin
            oi_blk_d = '0;
            oi_fin_d = 1'b1;
          end else begin
            oi_blk_d = oi_blk_q + BLK_W'(1);
          end
        end else begin
          oi_ptr_d = oi_ptr_q + O_AW'(1);
        end
      end

      if (acc_oo) begin
        if (oo_ptr_q == O_LAST) begin
          oo_ptr_d = '0;
          if (oo_blk_q == blk_last) begin
            oo_blk_d = '0;
            oo_fin_d = 1'b1;
          end else begin
            oo_blk_d = oo_blk_q + BLK_W'(1);
          end
        end else begin
          oo_ptr_d = oo_ptr_q + O_AW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            overrun_d = 1'b0;
            if (cfg_blocks_i != '0) begin
              cfg_d    = cfg_blocks_i;
              i_ptr_d  = '0;
              oi_ptr_d = '0;
              oo_ptr_d = '0;
              i_blk_d  = '0;
              oi_blk_d = '0;
              oo_blk_d = '0;
              i_fin_d  = 1'b0;
              oi_fin_d = 1'b0;
              oo_fin_d = 1'b0;
              state_d  = RUN;
            end else begin
              state_d  = DONE;
            end
          end
        end
        RUN: begin
          // Next-state flags so same-cycle final strobes complete at once.
          if (i_fin_d && oi_fin_d && oo_fin_d) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Applied last so a rejected strobe is never lost, even beside a start.
      if ((en_i_i && !acc_i) || (en_oi_i && !acc_oi) || (en_oo_i && !acc_oo)) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      w_ptr_q   <= '0;
      i_ptr_q   <= '0;
      oi_ptr_q  <= '0;
      oo_ptr_q  <= '0;
      i_blk_q   <= '0;
      oi_blk_q  <= '0;
      oo_blk_q  <= '0;
      i_fin_q   <= 1'b0;
      oi_fin_q  <= 1'b0;
      oo_fin_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      w_ptr_q   <= w_ptr_d;
      i_ptr_q   <= i_ptr_d;
      oi_ptr_q  <= oi_ptr_d;
      oo_ptr_q  <= oo_ptr_d;
      i_blk_q   <= i_blk_d;
      oi_blk_q  <= oi_blk_d;
      oo_blk_q  <= oo_blk_d;
      i_fin_q   <= i_fin_d;
      oi_fin_q  <= oi_fin_d;
      oo_fin_q  <= oo_fin_d;
      overrun_q <= overrun_d;
    end
  end

  assign w_addr_o  = w_ptr_q;
  assign i_addr_o  = (i_blk_q == '0) ? i_ptr_q : i_ptr_q + I_SHIFT;
  assign oi_addr_o = oi_ptr_q;
  assign oo_addr_o = oo_ptr_q;
  assign i_blk_o   = i_blk_q;
  assign oi_blk_o  = oi_blk_q;
  assign oo_blk_o  = oo_blk_q;
  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pe_dataflow_sequencer.sv
// Directed bench for pe_dataflow_sequencer at default parameters
// (W_GROUP=4, O_GROUP=4, I_GROUP=7).
module tb_pe_dataflow_sequencer;

  logic       clk = 1'b0;
  logic       aclr;
  logic       sclr_i, start_i;
  logic [3:0] cfg_blocks_i;
  logic       en_w_i, en_i_i, en_oi_i, en_oo_i;
  logic [1:0] w_addr_o;
  logic [2:0] i_addr_o;
  logic [1:0] oi_addr_o, oo_addr_o;
  logic [3:0] i_blk_o, oi_blk_o, oo_blk_o;
  logic       busy_o, done_o, overrun_o;

  int nvec = 0;
  int nmis = 0;

  pe_dataflow_sequencer dut (
    .clk(clk), .aclr(aclr), .sclr_i(sclr_i), .start_i(start_i),
    .cfg_blocks_i(cfg_blocks_i), .en_w_i(en_w_i), .en_i_i(en_i_i),
    .en_oi_i(en_oi_i), .en_oo_i(en_oo_i), .w_addr_o(w_addr_o),
    .i_addr_o(i_addr_o), .oi_addr_o(oi_addr_o), .oo_addr_o(oo_addr_o),
    .i_blk_o(i_blk_o), .oi_blk_o(oi_blk_o), .oo_blk_o(oo_blk_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sclr_i = 0; start_i = 0; en_w_i = 0; en_i_i = 0; en_oi_i = 0; en_oo_i = 0;
  endtask

  logic [2:0] exp_i [11];
  logic [1:0] exp_w [5];

  initial begin
    exp_i = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6};
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    idle_inputs();
    cfg_blocks_i = 0;
    aclr = 1;
    #3;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_w_addr", w_addr_o, 0);
    chk("rst_i_addr", i_addr_o, 0);
    cyc();
    aclr = 0;
    cyc();

    // cfg=2 job: 11 input strobes with 8 oi/oo strobes in the first 8 cycles
    cfg_blocks_i = 2; start_i = 1;
    cyc();
    start_i = 0;
    chk("start_busy", busy_o, 1);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("j1_i_addr_%0d", k), i_addr_o, exp_i[k]);
      chk($sformatf("j1_i_blk_%0d", k), i_blk_o, (k >= 7) ? 1 : 0);
      if (k < 8) chk($sformatf("j1_oi_addr_%0d", k), oi_addr_o, k % 4);
      chk($sformatf("j1_done_low_%0d", k), done_o, 0);
      en_i_i = 1; en_oi_i = (k < 8); en_oo_i = (k < 8);
      cyc();
    end
    idle_inputs();
    chk("j1_done", done_o, 1);
    chk("j1_busy_fall", busy_o, 0);
    chk("j1_i_blk_final", i_blk_o, 0);
    chk("j1_i_addr_final", i_addr_o, 0);
    chk("j1_overrun", overrun_o, 0);
    cyc();
    chk("j1_done_one_cycle", done_o, 0);
    chk("j1_idle_busy", busy_o, 0);

    // cfg=1: final I, OI and OO strobes in the same cycle
    cfg_blocks_i = 1; start_i = 1;
    cyc();
    start_i = 0;
    for (int k = 0; k < 7; k++) begin
      en_i_i = 1; en_oi_i = (k >= 3); en_oo_i = (k >= 3);
      cyc();
      if (k < 6) chk($sformatf("j2_busy_%0d", k), busy_o, 1);
    end
    idle_inputs();
    chk("j2_done", done_o, 1);
    chk("j2_overrun", overrun_o, 0);
    cyc();
    chk("j2_single_done", done_o, 0);

    // cfg=1: extra en_oo after OO has finished
    cfg_blocks_i = 1; start_i = 1;
    cyc();
    start_i = 0;
    for (int k = 0; k < 4; k++) begin
      en_oo_i = 1;
      cyc();
    end
    chk("j3_oo_addr_fin", oo_addr_o, 0);
    chk("j3_overrun_clean", overrun_o, 0);
    en_oo_i = 1;
    cyc();
    en_oo_i = 0;
    chk("j3_oo_addr_extra", oo_addr_o, 0);
    chk("j3_overrun_set", overrun_o, 1);
    chk("j3_busy", busy_o, 1);
    for (int k = 0; k < 7; k++) begin
      en_i_i = 1; en_oi_i = (k >= 3);
      cyc();
    end
    idle_inputs();
    chk("j3_done", done_o, 1);
    chk("j3_overrun_sticky", overrun_o, 1);
    cyc();

    // cfg=0 start: immediate done, clears overrun, no RUN cycle
    cfg_blocks_i = 0; start_i = 1;
    cyc();
    start_i = 0;
    chk("z_done", done_o, 1);
    chk("z_busy", busy_o, 0);
    chk("z_overrun_clr", overrun_o, 0);
    cyc();
    chk("z_done_fall", done_o, 0);
    chk("z_busy_after", busy_o, 0);

    // en_i in IDLE is rejected
    en_i_i = 1;
    cyc();
    en_i_i = 0;
    chk("idle_en_i_addr", i_addr_o, 0);
    chk("idle_en_i_overrun", overrun_o, 1);
    sclr_i = 1;
    cyc();
    sclr_i = 0;
    chk("sclr_overrun", overrun_o, 0);

    // weight stream wraps in IDLE
    for (int k = 0; k < 5; k++) begin
      en_w_i = 1;
      cyc();
      chk($sformatf("w_addr_%0d", k), w_addr_o, exp_w[k]);
    end
    en_w_i = 0;

    // aclr mid-block
    cfg_blocks_i = 3; start_i = 1;
    cyc();
    start_i = 0;
    for (int k = 0; k < 7; k++) begin
      en_i_i = 1; en_oo_i = (k < 2);
      cyc();
    end
    idle_inputs();
    chk("pre_aclr_i_blk", i_blk_o, 1);
    chk("pre_aclr_i_addr", i_addr_o, 3);
    chk("pre_aclr_oo_addr", oo_addr_o, 2);
    #2 aclr = 1;
    #1;
    chk("aclr_i_blk", i_blk_o, 0);
    chk("aclr_i_addr", i_addr_o, 0);
    chk("aclr_oo_addr", oo_addr_o, 0);
    chk("aclr_w_addr", w_addr_o, 0);
    chk("aclr_busy", busy_o, 0);
    #2 aclr = 0;
    cyc();
    chk("aclr_no_done", done_o, 0);
    chk("aclr_idle", busy_o, 0);

    // sclr beats start
    sclr_i = 1; start_i = 1; cfg_blocks_i = 2;
    cyc();
    idle_inputs();
    chk("sclr_start_busy", busy_o, 0);
    chk("sclr_start_done", done_o, 0);
    cyc();
    chk("sclr_start_busy2", busy_o, 0);
    chk("sclr_start_done2", done_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_dataflow_sequencer.md
PE_DATAFLOW_SEQUENCER -- requirements
Module: pe_dataflow_sequencer

Interface
REQ-001 SHALL have parameter W_GROUP, 4, weight PE group size (>=2).
REQ-002 SHALL have parameter O_GROUP, 4, output PE group size (>=2).
REQ-003 SHALL have parameter I_GROUP, W_GROUP+O_GROUP-1, input PE group size.
REQ-004 SHALL have parameters W_AW, O_AW, I_AW, defaults 2, 2, 3, address widths (each >= clog2 of its group size).
REQ-005 SHALL have parameter BLK_W, 4, block counter / cfg_blocks width.
REQ-006 SHALL have ports clk in 1 clock, and aclr in 1 reset: asynchronous, active-high.
REQ-007 SHALL have ports sclr in 1 sync clear; start in 1 job start pulse; cfg_blocks in BLK_W blocks per job.
REQ-008 SHALL have ports en_w, en_i, en_oi, en_oo, each in 1: per-stream advance strobes for weight, input, output-in, output-out.
REQ-009 SHALL have ports w_addr out W_AW; i_addr out I_AW; oi_addr out O_AW; oo_addr out O_AW: PE addresses.
REQ-010 SHALL have ports i_blk, oi_blk, oo_blk, each out BLK_W: per-stream block index.
REQ-011 SHALL have ports busy out 1 job active; done out 1 one-cycle completion pulse; overrun out 1 sticky protocol error.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; busy=1 only in RUN; done=1 only in DONE, for exactly one cycle.
REQ-013 IDLE + start + cfg_blocks>=1: SHALL latch cfg_blocks, clear all pointers, block counters and finished flags, clear overrun, enter RUN.
REQ-014 IDLE + start + cfg_blocks==0: SHALL go directly to DONE (one done pulse, no RUN cycle).
REQ-015 start in RUN or DONE SHALL be ignored.
REQ-016 Weight stream: each en_w SHALL advance w_addr, wrapping W_GROUP-1 -> 0; it runs in any state, has no block counter and does not gate completion.
REQ-017 Each accepted en_oi/en_oo SHALL advance its pointer; at O_GROUP-1 the pointer SHALL wrap to 0 and the stream's block counter SHALL increment.
REQ-018 Input stream block length: I_GROUP in block 0, O_GROUP in blocks >0; at its last entry the pointer SHALL wrap to 0 and i_blk SHALL increment.
REQ-019 i_addr SHALL equal i_ptr when i_blk==0, else i_ptr+(W_GROUP-1) (sliding-window reuse; max I_GROUP-1).
REQ-020 Each stream's block counter SHALL advance only on its own enable; streams SHALL advance independently in the same cycle.
REQ-021 On wrap when the counter equals latched cfg_blocks-1, the stream SHALL set its finished flag and return its counter and pointer to 0.
REQ-022 I, OI and OO streams SHALL accept enables only in RUN and only while unfinished; any other en_i/en_oi/en_oo SHALL be ignored and set overrun.
REQ-023 When all three finished flags are set (including same-cycle final strobes), the FSM SHALL enter DONE on the next edge; done is asserted the cycle after the last accepted strobe.
REQ-024 overrun SHALL stay set until sclr, aclr or an accepted start.
REQ-025 sclr SHALL have priority over start and all enables, returning every register to reset values.
REQ-026 Block counters SHALL never exceed cfg_blocks-1; no arithmetic overflow occurs for cfg_blocks up to 2^BLK_W-1.

Reset
REQ-027 aclr SHALL immediately force state IDLE; all addresses, block indices, finished flags and latched cfg to 0; busy=0, done=0, overrun=0.
REQ-028 aclr or sclr mid-job SHALL abort the job with no done pulse.

Verification
REQ-029 Defaults, cfg_blocks=2, start, 7 en_i -> i_addr 0..6 then i_blk=1; 4 more en_i -> i_addr 3,4,5,6; then I finished, i_blk=0.
REQ-030 cfg_blocks=2, 8 en_oi and 8 en_oo interleaved with REQ-029 strobes -> done high exactly one cycle after last accepted strobe, busy falls with it.
REQ-031 Final en_i, en_oi, en_oo strobes in the same cycle -> single done pulse next cycle; no overrun.
REQ-032 Extra en_oo after OO finished, or en_i in IDLE -> address unchanged, overrun=1 until next start.
REQ-033 Start with cfg_blocks=0 -> done pulse next cycle, busy never asserted; 5 en_w in IDLE -> w_addr 1,2,3,0,1.
REQ-034 aclr pulse mid-block (i_blk=1, oo_addr=2) -> all outputs 0 immediately, no done; sclr plus start same cycle -> remains IDLE.
